sad_abs_accum: RTL and testbench
================================

Name: sad_abs_accum

Overview:
Parametrised successor to the combinational absolute-value unit of the SAD datapath. It takes pairs of pixel samples, forms |a-b| in a pipelined difference/absolute stage and accumulates BLOCK_LEN consecutive values into one sum-of-absolute-differences result. Handshakes are valid/ready on both sides. It sits between the pixel fetch stage and the SAD comparator/minimum-search logic.

Parameters:
DATA_W, 8, width of each input sample.
SIGNED, 0, 0 = inputs unsigned; 1 = inputs two's-complement signed.
BLOCK_LEN, 16, samples per SAD block; legal range is 1 to 65535.
ACC_W, 16, width of the accumulator and result; the sum saturates at 2^ACC_W-1.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  sample pair present.
in_ready  out  1  block can accept a sample pair this cycle.
in_a  in  DATA_W  sample A.
in_b  in  DATA_W  sample B.
out_valid  out  1  SAD result available.
out_ready  in  1  consumer accepts the result.
out_sad  out  ACC_W  SAD of the block.
out_ovf  out  1  the block sum saturated.

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- Reset state:
  - in_ready=1, out_valid=0, out_sad=0, out_ovf=0.
  - Accumulator, sample counter and all pipeline valid bits are 0.
- Stall signal: en = !(out_valid && !out_ready).
  - in_ready = en.
  - When en=0, every pipeline register, the counter and the accumulator hold their values. No data is lost or duplicated.
- A sample is accepted when in_valid && in_ready.
- Stage 1 (register, cycle t+1): diff = a - b, computed at DATA_W+1 bits.
  - SIGNED=0: operands are zero-extended.
  - SIGNED=1: operands are sign-extended.
- Stage 2 (register, cycle t+2): absval = |diff|, DATA_W+1 bits unsigned.
  - SIGNED=0: absval never exceeds 2^DATA_W-1.
  - SIGNED=1: the maximum is 2^DATA_W-1 (-128 vs 127 gives 255). No overflow is possible.
- Stage 3 (accumulate, cycle t+3): sum = acc + absval, computed at ACC_W+1 bits.
  - If sum exceeds 2^ACC_W-1, the result is clamped to 2^ACC_W-1 and a sticky per-block ovf bit is set.
- Counter: cnt counts 0..BLOCK_LEN-1 and increments on each stage-3 valid with en=1.
  - On the value with cnt==BLOCK_LEN-1:
    - out_sad <= saturated sum.
    - out_ovf <= ovf | (this addition saturated).
    - out_valid <= 1.
    - acc <= 0, ovf <= 0, cnt <= 0.
- Latency: the last sample of a block is accepted at cycle t, and out_valid=1 at cycle t+3 (no stall). Throughput is 1 sample/cycle.
- Output handshake:
  - out_sad and out_ovf stay stable while out_valid && !out_ready.
  - out_valid drops on the cycle after out_valid && out_ready, unless a new result completes that same cycle. In that case out_valid stays 1 and the new value replaces the old.
- Bubbles: cycles with in_valid=0 insert bubbles. The counter advances only on valid stage-3 data.
- BLOCK_LEN=1: every sample produces a result, i.e. out_sad = |a-b|.
- Reset mid-block or mid-stall: the partial sum, pending result and in-flight samples are discarded. The next accepted sample starts a new block.
- The counter width is 16 bits.

Test Plan:
1. Basic unsigned block (DATA_W=8, BLOCK_LEN=4, ACC_W=16, SIGNED=0). Pairs (10,3), (3,10), (255,0), (0,0) on consecutive cycles with out_ready=1 -> out_sad=269, out_ovf=0, out_valid high exactly 3 cycles after the 4th accept, for 1 cycle.
2. Signed extremes (SIGNED=1, BLOCK_LEN=2). Pairs (0x80,0x7F), (0x7F,0x80) -> out_sad=510; no overflow.
3. Backpressure. Run 3 back-to-back blocks of 4 with out_ready held low for 6 cycles after the first result -> in_ready=0 throughout the stall, out_sad held, all three sums correct and in order.
4. Saturation (ACC_W=9, BLOCK_LEN=4). Four pairs (255,0) -> out_sad=511, out_ovf=1. The next block of (1,0) gives out_sad=4, out_ovf=0.
5. Reset mid-block. Accept 2 samples of a 4-block, assert rst for 1 cycle, then send 4 pairs (2,1) -> out_sad=4; no output from the aborted block.
6. BLOCK_LEN=1 with bubbles. Pairs (5,9), bubble, (9,5) -> two results of 4, each 3 cycles after its accept.

Source files
------------

// File: rtl/sad_abs_accum.sv
// Sum of |a-b| over BLOCK_LEN sample pairs: diff and abs register stages feed a saturating accumulator.
// Result is valid 3 cycles after a block's last accept; an unconsumed result freezes the pipe and drops in_ready.
module sad_abs_accum #(
    parameter int DATA_W    = 8,
    parameter int SIGNED    = 0,
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sad,
    output logic              out_ovf
);
    localparam int          DW1   = DATA_W + 1;
    // Wide enough that acc + absval can never wrap, whichever operand is wider.
    localparam int          SUM_W = ((ACC_W > DW1) ? ACC_W : DW1) + 1;
    localparam logic [15:0] LAST  = 16'(BLOCK_LEN - 1);

    logic             w_en;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [DW1-1:0]   w_diff;
    logic [DW1-1:0]   w_abs;
    logic [SUM_W-1:0] w_sum;
    logic             w_sat_hit;
    logic [ACC_W-1:0] w_sat_val;
    logic             w_last;

    logic             r_s1_vld;
    logic [DW1-1:0]   r_s1_diff;
    logic             r_s2_vld;
    logic [DW1-1:0]   r_s2_abs;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [15:0]      r_cnt;
    logic             r_out_vld;
    logic [ACC_W-1:0] r_out_sad;
    logic             r_out_ovf;

    assign w_en     = !(r_out_vld && !out_ready);
    assign in_ready = w_en;

    assign w_sign_a = (SIGNED != 0) ? in_a[DATA_W-1] : 1'b0;
    assign w_sign_b = (SIGNED != 0) ? in_b[DATA_W-1] : 1'b0;
    assign w_diff   = {w_sign_a, in_a} - {w_sign_b, in_b};

    // |diff| <= 2^DATA_W-1 in both modes, so negating never overflows DW1 bits.
    assign w_abs = r_s1_diff[DATA_W] ? -r_s1_diff : r_s1_diff;

    assign w_sum     = {{(SUM_W-ACC_W){1'b0}}, r_acc} + {{(SUM_W-DW1){1'b0}}, r_s2_abs};
    assign w_sat_hit = |w_sum[SUM_W-1:ACC_W];
    assign w_sat_val = w_sat_hit ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_diff <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_abs  <= '0;
        end else if (w_en) begin
            r_s1_vld  <= in_valid;
            r_s1_diff <= w_diff;
            r_s2_vld  <= r_s1_vld;
            r_s2_abs  <= w_abs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_out_sad <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_en) begin
            // en=1 means any held result was just consumed, so valid follows completion directly.
            r_out_vld <= r_s2_vld && w_last;
            if (r_s2_vld) begin
                if (w_last) begin
                    r_out_sad <= w_sat_val;
                    r_out_ovf <= r_ovf | w_sat_hit;
                    r_acc     <= '0;
                    r_ovf     <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_acc     <= w_sat_val;
                    r_ovf     <= r_ovf | w_sat_hit;
                    r_cnt     <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_sad   = r_out_sad;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sad_abs_accum.sv
// Four configurations of sad_abs_accum driven side by side; results checked against a block-sum reference model.
module tb_sad_abs_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [4];
    logic        ir   [4];
    logic [7:0]  ia   [4];
    logic [7:0]  ib   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic [15:0] osad [4];
    logic        oovf [4];
    logic [8:0]  sad9;

    // 0: unsigned L=4 W=16, 1: signed L=2, 2: unsigned L=4 W=9, 3: unsigned L=1
    int blen [4] = '{4, 2, 4, 1};
    int accw [4] = '{16, 16, 9, 16};
    bit sgn  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int m_sum;
    int m_cnt;
    int q_sad [$];
    bit q_ovf [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sad_abs_accum #(.DATA_W(8), .SIGNED(0), .BLOCK_LEN(4), .ACC_W(16)) u_main (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sad(osad[0]), .out_ovf(oovf[0]));
    sad_abs_accum #(.DATA_W(8), .SIGNED(1), .BLOCK_LEN(2), .ACC_W(16)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sad(osad[1]), .out_ovf(oovf[1]));
    sad_abs_accum #(.DATA_W(8), .SIGNED(0), .BLOCK_LEN(4), .ACC_W(9)) u_sat (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sad(sad9), .out_ovf(oovf[2]));
    sad_abs_accum #(.DATA_W(8), .SIGNED(0), .BLOCK_LEN(1), .ACC_W(16)) u_one (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_a(ia[3]), .in_b(ib[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_sad(osad[3]), .out_ovf(oovf[3]));

    assign osad[2] = {7'd0, sad9};

    function automatic int absdiff(input int d, input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        if (sgn[d]) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // Reference: a block's result is its exact total clamped to the max, overflow iff the total exceeds it.
    task automatic model_accept(input int d, input logic [7:0] a, input logic [7:0] b);
        int maxv;
        maxv = (1 << accw[d]) - 1;
        m_sum += absdiff(d, a, b);
        m_cnt++;
        if (m_cnt == blen[d]) begin
            q_sad.push_back((m_sum > maxv) ? maxv : m_sum);
            q_ovf.push_back(m_sum > maxv);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            ia[i] = 8'd0;
            ib[i] = 8'd0;
            ordy[i] = 1'b1;
        end
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        q_sad.delete();
        q_ovf.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (ir[d] !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, ir[d]); end
            vectors++;
            if (ov[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, ov[d]); end
            vectors++;
            if (osad[d] !== 16'd0) begin miscompares++; $display("FAIL reset_out_sad[%0d]: got %0d want 0", d, osad[d]); end
            vectors++;
            if (oovf[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf[%0d]: got %b want 0", d, oovf[d]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] a_t [4] = '{8'd10, 8'd3, 8'd255, 8'd0};
        logic [7:0] b_t [4] = '{8'd3, 8'd10, 8'd0, 8'd0};
        int last_acc = -100;
        int n_out = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin iv[0] = 1'b1; ia[0] = a_t[i]; ib[0] = b_t[i]; end
            else iv[0] = 1'b0;
            @(negedge clk);
            if (iv[0] && ir[0]) last_acc = cyc;
            if (ov[0]) begin
                n_out++;
                vectors++;
                if (cyc - last_acc !== 3) begin miscompares++; $display("FAIL basic_latency: got %0d cycles want 3", cyc - last_acc); end
                vectors++;
                if (osad[0] !== 16'd269) begin miscompares++; $display("FAIL basic_sad: got %0d want 269", osad[0]); end
                vectors++;
                if (oovf[0] !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b want 0", oovf[0]); end
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (n_out !== 1) begin miscompares++; $display("FAIL basic_valid_cycles: got %0d want 1", n_out); end
    endtask

    task automatic test_signed();
        int n_out = 0;
        int e_sad;
        bit e_ovf;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            if (i == 0) begin iv[1] = 1'b1; ia[1] = 8'h80; ib[1] = 8'h7F; end
            else if (i == 1) begin iv[1] = 1'b1; ia[1] = 8'h7F; ib[1] = 8'h80; end
            else if (i < 40) begin iv[1] = ($urandom_range(0, 3) != 0); ia[1] = 8'($urandom); ib[1] = 8'($urandom); end
            else iv[1] = 1'b0;
            @(negedge clk);
            if (iv[1] && ir[1]) model_accept(1, ia[1], ib[1]);
            if (ov[1]) begin
                if (n_out == 0) begin
                    vectors++;
                    if (osad[1] !== 16'd510 || oovf[1] !== 1'b0) begin
                        miscompares++; $display("FAIL signed_extremes: got sad=%0d ovf=%b want sad=510 ovf=0", osad[1], oovf[1]);
                    end
                end
                vectors++;
                if (q_sad.size() == 0) begin
                    miscompares++; $display("FAIL signed_extra: unexpected result sad=%0d", osad[1]);
                end else begin
                    e_sad = q_sad.pop_front();
                    e_ovf = q_ovf.pop_front();
                    if (osad[1] !== 16'(e_sad) || oovf[1] !== e_ovf) begin
                        miscompares++; $display("FAIL signed_result: got sad=%0d ovf=%b want sad=%0d ovf=%b", osad[1], oovf[1], e_sad, e_ovf);
                    end
                end
                n_out++;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (q_sad.size() !== 0) begin miscompares++; $display("FAIL signed_missing: %0d results never seen, want 0", q_sad.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] sa [12];
        logic [7:0] sb [12];
        int idx = 0;
        int n_out = 0;
        int stall_left = 0;
        bit seen_first = 1'b0;
        logic [15:0] held = '0;
        int e_sad;
        bit e_ovf;
        do_reset();
        for (int i = 0; i < 12; i++) begin sa[i] = 8'($urandom); sb[i] = 8'($urandom); end
        ordy[0] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            iv[0] = (idx < 12);
            if (idx < 12) begin ia[0] = sa[idx]; ib[0] = sb[idx]; end
            @(negedge clk);
            if (ov[0] && !ordy[0]) begin
                vectors++;
                if (ir[0] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_stall: got %b want 0", ir[0]); end
                if (!seen_first) begin
                    seen_first = 1'b1;
                    held = osad[0];
                    stall_left = 6;
                end else begin
                    vectors++;
                    if (osad[0] !== held) begin miscompares++; $display("FAIL bp_hold: got %0d want %0d", osad[0], held); end
                end
            end else begin
                vectors++;
                if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready_free: got %b want 1", ir[0]); end
            end
            if (iv[0] && ir[0]) begin model_accept(0, ia[0], ib[0]); idx++; end
            if (ov[0] && ordy[0]) begin
                vectors++;
                if (q_sad.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra: unexpected result sad=%0d", osad[0]);
                end else begin
                    e_sad = q_sad.pop_front();
                    e_ovf = q_ovf.pop_front();
                    if (osad[0] !== 16'(e_sad) || oovf[0] !== e_ovf) begin
                        miscompares++; $display("FAIL bp_result[%0d]: got sad=%0d ovf=%b want sad=%0d ovf=%b", n_out, osad[0], oovf[0], e_sad, e_ovf);
                    end
                end
                n_out++;
            end
            @(posedge clk);
            #1;
            if (seen_first && stall_left > 0) begin
                stall_left--;
                ordy[0] = (stall_left == 0);
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        vectors++;
        if (n_out !== 3) begin miscompares++; $display("FAIL bp_count: got %0d results want 3", n_out); end
    endtask

    task automatic test_saturation();
        int n_out = 0;
        int e_sad;
        bit e_ovf;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            if (i < 4) begin iv[2] = 1'b1; ia[2] = 8'd255; ib[2] = 8'd0; end
            else if (i < 8) begin iv[2] = 1'b1; ia[2] = 8'd1; ib[2] = 8'd0; end
            else if (i < 40) begin iv[2] = ($urandom_range(0, 4) != 0); ia[2] = 8'($urandom); ib[2] = 8'($urandom); end
            else iv[2] = 1'b0;
            @(negedge clk);
            if (iv[2] && ir[2]) model_accept(2, ia[2], ib[2]);
            if (ov[2]) begin
                if (n_out == 0) begin
                    vectors++;
                    if (osad[2] !== 16'd511 || oovf[2] !== 1'b1) begin
                        miscompares++; $display("FAIL sat_clamp: got sad=%0d ovf=%b want sad=511 ovf=1", osad[2], oovf[2]);
                    end
                end else if (n_out == 1) begin
                    vectors++;
                    if (osad[2] !== 16'd4 || oovf[2] !== 1'b0) begin
                        miscompares++; $display("FAIL sat_next_block: got sad=%0d ovf=%b want sad=4 ovf=0", osad[2], oovf[2]);
                    end
                end
                vectors++;
                if (q_sad.size() == 0) begin
                    miscompares++; $display("FAIL sat_extra: unexpected result sad=%0d", osad[2]);
                end else begin
                    e_sad = q_sad.pop_front();
                    e_ovf = q_ovf.pop_front();
                    if (osad[2] !== 16'(e_sad) || oovf[2] !== e_ovf) begin
                        miscompares++; $display("FAIL sat_result: got sad=%0d ovf=%b want sad=%0d ovf=%b", osad[2], oovf[2], e_sad, e_ovf);
                    end
                end
                n_out++;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (q_sad.size() !== 0) begin miscompares++; $display("FAIL sat_missing: %0d results never seen, want 0", q_sad.size()); end
    endtask

    task automatic test_reset_mid();
        int n_out = 0;
        do_reset();
        iv[0] = 1'b1; ia[0] = 8'd200; ib[0] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        iv[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            iv[0] = (i < 4); ia[0] = 8'd2; ib[0] = 8'd1;
            @(negedge clk);
            if (ov[0]) begin
                n_out++;
                vectors++;
                if (osad[0] !== 16'd4 || oovf[0] !== 1'b0) begin
                    miscompares++; $display("FAIL rstmid_result: got sad=%0d ovf=%b want sad=4 ovf=0", osad[0], oovf[0]);
                end
            end
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        vectors++;
        if (n_out !== 1) begin miscompares++; $display("FAIL rstmid_count: got %0d results want 1", n_out); end
    endtask

    task automatic test_len1_bubbles();
        int acc_q [$];
        int n_out = 0;
        int t0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            iv[3] = (i == 0) || (i == 2);
            ia[3] = (i == 0) ? 8'd5 : 8'd9;
            ib[3] = (i == 0) ? 8'd9 : 8'd5;
            @(negedge clk);
            if (iv[3] && ir[3]) acc_q.push_back(cyc);
            if (ov[3]) begin
                n_out++;
                vectors++;
                if (osad[3] !== 16'd4 || oovf[3] !== 1'b0) begin
                    miscompares++; $display("FAIL len1_result: got sad=%0d ovf=%b want sad=4 ovf=0", osad[3], oovf[3]);
                end
                t0 = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                vectors++;
                if (cyc - t0 !== 3) begin miscompares++; $display("FAIL len1_latency: got %0d cycles want 3", cyc - t0); end
            end
            @(posedge clk);
            #1;
        end
        iv[3] = 1'b0;
        vectors++;
        if (n_out !== 2) begin miscompares++; $display("FAIL len1_count: got %0d results want 2", n_out); end
    endtask

    task automatic test_back_to_back(input int d);
        bit hold_in = 1'b0;
        bit prev_stall = 1'b0;
        logic [15:0] prev_sad = '0;
        logic prev_ovf = 1'b0;
        int e_sad;
        bit e_ovf;
        do_reset();
        for (int c = 0; c < 320; c++) begin
            if (c >= 300) begin
                iv[d] = 1'b0;
                ordy[d] = 1'b1;
            end else begin
                if (!hold_in) begin
                    iv[d] = ($urandom_range(0, 3) != 0);
                    ia[d] = 8'($urandom);
                    ib[d] = 8'($urandom);
                end
                ordy[d] = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            if (prev_stall) begin
                vectors++;
                if (ov[d] !== 1'b1 || osad[d] !== prev_sad || oovf[d] !== prev_ovf) begin
                    miscompares++; $display("FAIL b2b_hold[%0d]: got vld=%b sad=%0d ovf=%b want vld=1 sad=%0d ovf=%b", d, ov[d], osad[d], oovf[d], prev_sad, prev_ovf);
                end
            end
            vectors++;
            if (ir[d] !== !(ov[d] && !ordy[d])) begin
                miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b with out_valid=%b out_ready=%b", d, ir[d], ov[d], ordy[d]);
            end
            hold_in = iv[d] && !ir[d];
            if (iv[d] && ir[d]) model_accept(d, ia[d], ib[d]);
            if (ov[d] && ordy[d]) begin
                vectors++;
                if (q_sad.size() == 0) begin
                    miscompares++; $display("FAIL b2b_extra[%0d]: unexpected result sad=%0d", d, osad[d]);
                end else begin
                    e_sad = q_sad.pop_front();
                    e_ovf = q_ovf.pop_front();
                    if (osad[d] !== 16'(e_sad) || oovf[d] !== e_ovf) begin
                        miscompares++; $display("FAIL b2b_result[%0d]: got sad=%0d ovf=%b want sad=%0d ovf=%b", d, osad[d], oovf[d], e_sad, e_ovf);
                    end
                end
            end
            prev_stall = ov[d] && !ordy[d];
            prev_sad = osad[d];
            prev_ovf = oovf[d];
            @(posedge clk);
            #1;
        end
        vectors++;
        if (q_sad.size() !== 0) begin miscompares++; $display("FAIL b2b_missing[%0d]: %0d results never seen, want 0", d, q_sad.size()); end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_len1_bubbles();
        for (int d = 0; d < 4; d++) test_back_to_back(d);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
